alt_cal_dprio_ctrl: RTL
=======================

ALT_CAL_DPRIO_CTRL -- requirements
Module: alt_cal_dprio_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clock cycles per serial bit-time (legal 1..16).
REQ-002 SHALL have parameter RD_TURNAROUND, default 1, idle bit-times between read header and read data (legal 0..3).
REQ-003 SHALL have port clock  input  1  sole clock; all logic on posedge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dprio_addr  input  16  register address from calibration engine.
REQ-006 SHALL have port dprio_dataout  input  16  write data from calibration engine.
REQ-007 SHALL have ports dprio_rden / dprio_wren  input  1 each  read / write request strobes.
REQ-008 SHALL have port quad_addr  input  9  target quad select.
REQ-009 SHALL have port dprio_datain  output  16  read data returned to engine.
REQ-010 SHALL have port dprio_busy  output  1  transaction in flight.
REQ-011 SHALL have port dprio_rdvalid  output  1  one-cycle read-data-valid pulse.
REQ-012 SHALL have port proto_err  output  1  one-cycle pulse: rden and wren both high at acceptance.
REQ-013 SHALL have ports dp_sdo out 1 (serial data, MSB first), dp_sdi in 1 (serial read data), dp_load out 1 (frame active), dp_disable out 1 (serial port disabled).

Function
REQ-014 SHALL accept a request when (dprio_rden|dprio_wren) & ~dprio_busy; all inputs captured that cycle; requests while busy ignored.
REQ-015 SHALL, on rden & wren simultaneous, execute a write and pulse proto_err in the cycle after acceptance.
REQ-016 SHALL implement states IDLE -> ADDR -> GAP -> (WRITE | READ) -> DONE -> IDLE.
REQ-017 SHALL send ADDR frame of 27 bits: opcode 2'b00, quad_addr[8:0], dprio_addr[15:0].
REQ-018 SHALL send WRITE frame of 27 bits: opcode 2'b01, quad_addr, captured write data.
REQ-019 SHALL send READ header of 11 bits: opcode 2'b11, quad_addr; then RD_TURNAROUND bit-times with dp_sdo=0; then sample 16 bits MSB first from dp_sdi on the last cycle of each bit-time.
REQ-020 SHALL hold each bit on dp_sdo for exactly CLK_DIV cycles; dp_load high for every frame cycle, low in GAP (one bit-time) and outside frames.
REQ-021 SHALL assert dprio_busy from the cycle after acceptance through the DONE cycle inclusive; with CLK_DIV=1, RD_TURNAROUND=1: write busy 56 cycles, read busy 57 cycles.
REQ-022 SHALL, in DONE of a read, drive dprio_datain with sampled word and pulse dprio_rdvalid; dprio_datain holds until next read completes.
REQ-023 SHALL drive dp_disable low from acceptance until DONE, high otherwise.
REQ-024 SHALL accept a new request in the first cycle after DONE (back-to-back, no extra idle).

Reset
REQ-025 SHALL, on reset (including mid-frame), abort immediately to IDLE: dprio_busy=0, dprio_rdvalid=0, proto_err=0, dprio_datain=16'h0000, dp_sdo=0, dp_load=0, dp_disable=1.
REQ-026 SHALL ignore request strobes in the reset cycle.

Configuration
REQ-027 SHALL, with ALT_CAL_DPRIO_ADDR_CACHE_EN defined, remember the last fully sent {quad_addr,dprio_addr} and skip ADDR and GAP when the new request matches (write busy 28 cycles at CLK_DIV=1); cache invalidated by reset and by any aborted ADDR frame.
REQ-028 SHALL, without the macro, always send the ADDR frame; no cache registers synthesized.

Structure
REQ-029 SHALL place opcodes, frame lengths (27, 11, 16), and the state enum in package alt_cal_dprio_pkg.
REQ-030 SHALL use one sub-module alt_cal_dprio_shifter: CLK_DIV bit-tick counter, 27-bit load/shift register, bit counter, serial-in capture.

Verification
REQ-031 SHALL test write: CLK_DIV=1, quad 9'h005, addr 16'h0123, data 16'hBEEF -> ADDR frame bits 00_000000101_0000000100100011, 1 gap cycle, WRITE frame 01_000000101_1011111011101111, busy 56 cycles.
REQ-032 SHALL test read: dp_sdi drives 16'hA55A after 1 turnaround -> dprio_rdvalid pulse with dprio_datain=16'hA55A, busy 57 cycles.
REQ-033 SHALL test CLK_DIV=4 write -> each dp_sdo bit stable 4 cycles, busy 221 cycles.
REQ-034 SHALL test rden=wren=1 -> write frame issued, proto_err single pulse, no rdvalid.
REQ-035 SHALL test reset asserted at cycle 10 of a write -> next cycle all outputs at reset values, following request starts a fresh ADDR frame.
REQ-036 SHALL test with ALT_CAL_DPRIO_ADDR_CACHE_EN two writes to same quad/addr -> second skips ADDR frame, busy 28 cycles.

Source files
------------

// File: rtl/alt_cal_dprio_pkg.sv
// Shared constants for the DPRIO serial controller: opcodes, frame lengths,
// FSM state encodings and the 27-bit frame builders.
package alt_cal_dprio_pkg;

  localparam int FRAME_LEN = 27;
  localparam int HDR_LEN   = 11;
  localparam int DATA_LEN  = 16;

  localparam logic [4:0] LEN_FRAME = 5'd27;
  localparam logic [4:0] LEN_GAP   = 5'd1;

  localparam logic [1:0] OP_ADDR  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic logic [26:0] make_frame(input logic [1:0] op, input logic [8:0] quad,
                                             input logic [15:0] word);
    return {op, quad, word};
  endfunction

  // A read header is left-aligned so the trailing zeros cover turnaround and data phase.
  function automatic logic [26:0] body_frame(input logic wr, input logic [8:0] quad,
                                             input logic [15:0] wdata);
    if (wr) begin
      return make_frame(OP_WRITE, quad, wdata);
    end else begin
      return make_frame(OP_READ, quad, 16'h0000);
    end
  endfunction

endpackage

// File: rtl/alt_cal_dprio_ctrl_if.sv
// Calibration-engine side request/response bundle of the DPRIO controller.
interface alt_cal_dprio_ctrl_if;
  logic [15:0] dprio_addr;
  logic [15:0] dprio_dataout;
  logic        dprio_rden;
  logic        dprio_wren;
  logic [8:0]  quad_addr;
  logic [15:0] dprio_datain;
  logic        dprio_busy;
  logic        dprio_rdvalid;
  logic        proto_err;

  modport master (
    output dprio_addr, dprio_dataout, dprio_rden, dprio_wren, quad_addr,
    input  dprio_datain, dprio_busy, dprio_rdvalid, proto_err
  );

  modport slave (
    input  dprio_addr, dprio_dataout, dprio_rden, dprio_wren, quad_addr,
    output dprio_datain, dprio_busy, dprio_rdvalid, proto_err
  );
endinterface

// File: rtl/alt_cal_dprio_shifter.sv
// Serial engine: bit-time divider, 27-bit MSB-first shift register, bit counter
// and dp_sdi capture on the last cycle of every bit-time.
module alt_cal_dprio_shifter
  import alt_cal_dprio_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [26:0] frame_i,
  input  logic [4:0]  nbits_i,
  input  logic        sdi_i,
  output logic        sdo_o,
  output logic        last_o,
  output logic [15:0] rd_word_o
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [26:0]      sh_q, sh_d;
  logic [14:0]      cap_q, cap_d;
  logic             act_q, act_d;
  logic             tick_s;

  assign tick_s    = act_q && (div_q == DIV_LAST);
  assign last_o    = tick_s && (bit_q == 5'd0);
  assign sdo_o     = sh_q[26];
  assign rd_word_o = {cap_q, sdi_i};

  always_comb begin
    div_d = div_q;
    bit_d = bit_q;
    sh_d  = sh_q;
    act_d = act_q;
    cap_d = cap_q;
    if (load_i) begin
      act_d = 1'b1;
      div_d = {DIV_W{1'b0}};
      bit_d = nbits_i - 5'd1;
      sh_d  = frame_i;
    end else if (tick_s) begin
      div_d = {DIV_W{1'b0}};
      bit_d = bit_q - 5'd1;
      sh_d  = {sh_q[25:0], 1'b0};
      act_d = (bit_q != 5'd0);
    end else if (act_q) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = {DIV_W{1'b0}};
    end
    if (tick_s) begin
      cap_d = {cap_q[13:0], sdi_i};
    end else begin
      cap_d = cap_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= {DIV_W{1'b0}};
      bit_q <= 5'd0;
      sh_q  <= 27'd0;
      cap_q <= 15'd0;
      act_q <= 1'b0;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
      cap_q <= cap_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/alt_cal_dprio_ctrl.sv
// DPRIO serial-port transaction controller (ADDR, GAP, WRITE/READ, DONE).
// Optional feature macro: ALT_CAL_DPRIO_ADDR_CACHE_EN skips ADDR+GAP on a repeated address.
module alt_cal_dprio_ctrl
  import alt_cal_dprio_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int RD_TURNAROUND = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  alt_cal_dprio_ctrl_if.slave  bus,
  output logic                 dp_sdo,
  input  logic                 dp_sdi,
  output logic                 dp_load,
  output logic                 dp_disable
);
  localparam logic [4:0] LEN_READ = 5'(HDR_LEN + RD_TURNAROUND + DATA_LEN);

  logic [2:0]  state_q, state_d;
  logic [8:0]  quad_q, quad_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        load_q, load_d;
  logic        dis_q, dis_d;
  logic        rdv_q, rdv_d;
  logic        perr_q, perr_d;
  logic [15:0] datain_q, datain_d;
  logic        accept_s;
  logic        sh_load_s;
  logic        sh_last_s;
  logic [26:0] sh_frame_s;
  logic [4:0]  sh_nbits_s;
  logic [15:0] sh_word_s;
`ifdef ALT_CAL_DPRIO_ADDR_CACHE_EN
  logic        cvld_q, cvld_d;
  logic [24:0] ctag_q, ctag_d;
`endif

  assign accept_s = (bus.dprio_rden | bus.dprio_wren) & ~busy_q;

  alt_cal_dprio_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clock     (clock),
    .reset     (reset),
    .load_i    (sh_load_s),
    .frame_i   (sh_frame_s),
    .nbits_i   (sh_nbits_s),
    .sdi_i     (dp_sdi),
    .sdo_o     (dp_sdo),
    .last_o    (sh_last_s),
    .rd_word_o (sh_word_s)
  );

  // Transaction sequencing; each phase change reloads the shifter on the same edge.
  always_comb begin
    state_d    = state_q;
    quad_d     = quad_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    datain_d   = datain_q;
    rdv_d      = 1'b0;
    perr_d     = 1'b0;
    sh_load_s  = 1'b0;
    sh_frame_s = 27'd0;
    sh_nbits_s = 5'd0;
`ifdef ALT_CAL_DPRIO_ADDR_CACHE_EN
    cvld_d     = cvld_q;
    ctag_d     = ctag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          quad_d    = bus.quad_addr;
          wdata_d   = bus.dprio_dataout;
          wr_d      = bus.dprio_wren;
          perr_d    = bus.dprio_rden & bus.dprio_wren;
          sh_load_s = 1'b1;
`ifdef ALT_CAL_DPRIO_ADDR_CACHE_EN
          if (cvld_q && (ctag_q == {bus.quad_addr, bus.dprio_addr})) begin
            state_d    = bus.dprio_wren ? ST_WRITE : ST_READ;
            sh_frame_s = body_frame(bus.dprio_wren, bus.quad_addr, bus.dprio_dataout);
            sh_nbits_s = bus.dprio_wren ? LEN_FRAME : LEN_READ;
          end else begin
            state_d    = ST_ADDR;
            sh_frame_s = make_frame(OP_ADDR, bus.quad_addr, bus.dprio_addr);
            sh_nbits_s = LEN_FRAME;
            cvld_d     = 1'b0;
            ctag_d     = {bus.quad_addr, bus.dprio_addr};
          end
`else
          state_d    = ST_ADDR;
          sh_frame_s = make_frame(OP_ADDR, bus.quad_addr, bus.dprio_addr);
          sh_nbits_s = LEN_FRAME;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (sh_last_s) begin
          state_d    = ST_GAP;
          sh_load_s  = 1'b1;
          sh_nbits_s = LEN_GAP;
`ifdef ALT_CAL_DPRIO_ADDR_CACHE_EN
          cvld_d     = 1'b1;
`endif
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_GAP: begin
        if (sh_last_s) begin
          state_d    = wr_q ? ST_WRITE : ST_READ;
          sh_load_s  = 1'b1;
          sh_frame_s = body_frame(wr_q, quad_q, wdata_q);
          sh_nbits_s = wr_q ? LEN_FRAME : LEN_READ;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_WRITE: begin
        if (sh_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        if (sh_last_s) begin
          state_d  = ST_DONE;
          rdv_d    = 1'b1;
          datain_d = sh_word_s;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    load_d = (state_d == ST_ADDR) || (state_d == ST_WRITE) || (state_d == ST_READ);
    dis_d  = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      quad_q   <= 9'd0;
      wdata_q  <= 16'h0000;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
      dis_q    <= 1'b1;
      rdv_q    <= 1'b0;
      perr_q   <= 1'b0;
      datain_q <= 16'h0000;
`ifdef ALT_CAL_DPRIO_ADDR_CACHE_EN
      cvld_q   <= 1'b0;
      ctag_q   <= 25'd0;
`endif
    end else begin
      state_q  <= state_d;
      quad_q   <= quad_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      load_q   <= load_d;
      dis_q    <= dis_d;
      rdv_q    <= rdv_d;
      perr_q   <= perr_d;
      datain_q <= datain_d;
`ifdef ALT_CAL_DPRIO_ADDR_CACHE_EN
      cvld_q   <= cvld_d;
      ctag_q   <= ctag_d;
`endif
    end
  end

  assign bus.dprio_busy    = busy_q;
  assign bus.dprio_rdvalid = rdv_q;
  assign bus.proto_err     = perr_q;
  assign bus.dprio_datain  = datain_q;
  assign dp_load           = load_q;
  assign dp_disable        = dis_q;

endmodule
